// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Includes the state encoding, forwarding selects and the shared forward decode.
package pipeline_ctrl_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MUL_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // MEM is the younger producer, so it wins over WB
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] mem_rd,
    input logic       mem_we,
    input logic [4:0] wb_rd,
    input logic       wb_we
  );
    if (mem_we && mem_rd != REG_ZERO && mem_rd == src)
      return FWD_MEM;
    else if (wb_we && wb_rd != REG_ZERO && wb_rd == src)
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// EX-stage operand forwarding select generation.
// Purely combinational; active regardless of controller state.
module forwarding_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] EX_Rs,
  input  logic [4:0] EX_Rt,
  input  logic [4:0] MEM_Rd,
  input  logic       MEM_RegWrite,
  input  logic [4:0] WB_Rd,
  input  logic       WB_RegWrite,
  output logic [1:0] Fwd_A,
  output logic [1:0] Fwd_B
);

  always_comb begin
    Fwd_A = fwd_sel(EX_Rs, MEM_Rd, MEM_RegWrite,
                    WB_Rd, WB_RegWrite);
    Fwd_B = fwd_sel(EX_Rt, MEM_Rd, MEM_RegWrite,
                    WB_Rd, WB_RegWrite);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: stalls, flushes, multiply wait,
// watchdog and stall counter for the 5-stage pipeline.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MUL_MAX_CYCLES = 32,
  parameter int CNT_W          = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_Uses_Rs,
  input  logic             ID_Uses_Rt,
  input  logic [4:0]       EX_Rs,
  input  logic [4:0]       EX_Rt,
  input  logic [4:0]       EX_Rd,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic             EX_Branch_Taken,
  input  logic             EX_Mul_Start,
  input  logic             Mul_Done,
  input  logic [4:0]       MEM_Rd,
  input  logic             MEM_RegWrite,
  input  logic [4:0]       WB_Rd,
  input  logic             WB_RegWrite,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Bubble,
  output logic [1:0]       Fwd_A,
  output logic [1:0]       Fwd_B,
  output logic             Mul_Timeout,
  output logic [CNT_W-1:0] Stall_Count
);

  localparam int WD_W =
    (MUL_MAX_CYCLES > 2) ? $clog2(MUL_MAX_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(MUL_MAX_CYCLES - 1);

  state_e           r_state;
  state_e           w_next;
  logic [WD_W-1:0]  r_wd;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_load_use;
  logic             w_wd_clr;
  logic             w_timeout_set;

  // EX_RegWrite is implied by EX_MemRead for loads
  logic w_unused;
  assign w_unused = EX_RegWrite;

  assign w_load_use = EX_MemRead && EX_Rd != REG_ZERO &&
    ((ID_Uses_Rs && ID_Rs == EX_Rd) ||
     (ID_Uses_Rt && ID_Rt == EX_Rd));

  always_comb begin
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Flush   = 1'b0;
    EX_MEM_Bubble = 1'b0;
    w_next        = r_state;
    w_wd_clr      = 1'b0;
    w_timeout_set = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (EX_Branch_Taken) begin
          IF_ID_Flush = 1'b1;
          ID_EX_Flush = 1'b1;
        end else if (EX_Mul_Start) begin
          PC_Write      = 1'b0;
          IF_ID_Write   = 1'b0;
          ID_EX_Write   = 1'b0;
          EX_MEM_Bubble = 1'b1;
          w_next        = ST_MUL_WAIT;
          w_wd_clr      = 1'b1;
        end else if (w_load_use) begin
          PC_Write    = 1'b0;
          IF_ID_Write = 1'b0;
          ID_EX_Flush = 1'b1;
        end
      end
      ST_MUL_WAIT: begin
        // release cycle drives the RUN defaults
        if (Mul_Done) begin
          w_next = ST_RUN;
        end else if (r_wd == WD_LAST) begin
          w_next        = ST_RUN;
          w_timeout_set = 1'b1;
        end else begin
          PC_Write      = 1'b0;
          IF_ID_Write   = 1'b0;
          ID_EX_Write   = 1'b0;
          EX_MEM_Bubble = 1'b1;
        end
      end
      default: w_next = ST_RUN;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= ST_RUN;
      r_wd        <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_wd_clr)
        r_wd <= '0;
      else if (r_state == ST_MUL_WAIT)
        r_wd <= r_wd + WD_W'(1);
      if (w_timeout_set)
        r_timeout <= 1'b1;
      if (!PC_Write && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign Mul_Timeout = r_timeout;
  assign Stall_Count = r_stall_cnt;

  forwarding_unit u_fwd (
    .EX_Rs        (EX_Rs),
    .EX_Rt        (EX_Rt),
    .MEM_Rd       (MEM_Rd),
    .MEM_RegWrite (MEM_RegWrite),
    .WB_Rd        (WB_Rd),
    .WB_RegWrite  (WB_RegWrite),
    .Fwd_A        (Fwd_A),
    .Fwd_B        (Fwd_B)
  );

endmodule
